prio_enc_queue: RTL and testbench

- Parametrised, registered successor to the combinational 5-to-3 priority encoder.
- Captures N request lines into a sticky pending register and emits one index per valid/ready handshake, serialising all set bits.
- Adds collision detection, backpressure and optional round-robin priority.
- Sits between interrupt/event sources and a single-index consumer such as an ALU or controller FSM.

---
 rtl/prio_enc_queue.sv | 149 ++++++++++++++
 tb/tb_prio_enc_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_queue.sv
// prio_enc_queue
//   Registered, handshaked successor to a combinational priority encoder.
//   Request bits are merged into a sticky pending register.
//   One index per valid/ready handshake is emitted, until every set bit has
//   been serialised out.
//   A request that lands on an already-pending bit raises the sticky ovf flag.
//
// Build option:
//   PRIO_ENC_QUEUE_RR_EN  when defined, the winner search starts at a rotating
//                         pointer (round-robin). When undefined, the lowest
//                         pending index always wins and no pointer exists.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_in     N request bits, bit i requests index i
//   req_valid  qualifies req_in
//   out_idx    current winner index (zero-extended to IDX_W)
//   out_valid  out_idx holds a valid winner (this is the HOLD/EMPTY state bit)
//   out_ready  consumer accepts out_idx this cycle
//   pending_o  pending register, for debug
//   ovf        sticky collision flag
//   clr_ovf    clears ovf (a same-cycle collision wins)
module prio_enc_queue #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  input  logic             req_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending_o,
  output logic             ovf,
  input  logic             clr_ovf
);

  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  logic             load;
  logic             have_win;
  logic             grant;
  logic             collision;
  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     clear_mask;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (IDX_W'(k) == idx) r[k] = 1'b1;
    end
    return r;
  endfunction

`ifdef PRIO_ENC_QUEUE_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     rot_pending;

  // (a + b) mod N for a, b < N; the sum fits in IDX_W+1 bits.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_W+1)'(N)) s = s - (IDX_W+1)'(N);
    return s[IDX_W-1:0];
  endfunction

  // Rotate pending right by the pointer, so bit 0 of the rotated vector is
  // pending[ptr]. The lowest set rotated bit is then mapped back to an
  // absolute index.
  always_comb begin
    rot_pending = N'({pending_q, pending_q} >> ptr_q);
    win_idx     = wrap_add(lowest_idx(rot_pending), ptr_q);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = wrap_add(win_idx, IDX_W'(1));
  end
`else
  always_comb begin
    win_idx = lowest_idx(pending_q);
  end
`endif

  // Winner comes from the registered pending value only; same-cycle
  // requests are merged afterwards, and a set dominates a clear.
  always_comb begin
    have_win    = |pending_q;
    load        = !out_valid_q || out_ready;
    grant       = load && have_win;
    clear_mask  = grant ? onehot(win_idx) : '0;
    collision   = req_valid && (|(req_in & pending_q & ~clear_mask));

    pending_d   = pending_q & ~clear_mask;
    if (req_valid) pending_d = pending_d | req_in;

    out_valid_d = load ? have_win : out_valid_q;
    out_idx_d   = grant ? win_idx : out_idx_q;

    ovf_d       = ovf_q;
    if (clr_ovf)   ovf_d = 1'b0;
    if (collision) ovf_d = 1'b1;
  end

  // Stage boundary: pending/output/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef PRIO_ENC_QUEUE_RR_EN
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign pending_o = pending_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_prio_enc_queue.sv
module tb_prio_enc_queue;
  localparam int N     = 5;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_in;
  logic             req_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     pending_o;
  logic             ovf;
  logic             clr_ovf;

  always #5 clk = ~clk;

  prio_enc_queue #(.N(N), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .req_valid (req_valid),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending_o (pending_o),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: pending set as an array of flags, a winner chosen
  // by scanning it, and the output/flag state kept as plain integers.
  bit m_pend [N];
  bit m_valid;
  int m_idx;
  bit m_ovf;
  int m_ptr;

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_update();
    int w;
    int c;
    bit ld;
    bit coll;
    if (rst) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_ovf   = 1'b0;
      m_ptr   = 0;
    end else begin
      ld = !m_valid || out_ready;
      w  = -1;
      if (ld) begin
        for (int k = 0; k < N; k++) begin
`ifdef PRIO_ENC_QUEUE_RR_EN
          c = (m_ptr + k) % N;
`else
          c = k;
`endif
          if (w < 0 && m_pend[c]) w = c;
        end
      end
      coll = 1'b0;
      for (int i = 0; i < N; i++)
        if (req_valid && req_in[i] && m_pend[i] && i != w) coll = 1'b1;
      if (w >= 0) m_pend[w] = 1'b0;
      if (req_valid)
        for (int i = 0; i < N; i++) if (req_in[i]) m_pend[i] = 1'b1;
      if (ld) begin
        if (w >= 0) begin
          m_valid = 1'b1;
          m_idx   = w;
          m_ptr   = (w + 1) % N;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (coll) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  endtask

  // Advance one clock: the model consumes the inputs the DUT samples at this
  // edge, and outputs are examined 1 time unit after the edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic             rst;
    logic             rv;
    logic [N-1:0]     req;
    logic             rdy;
    logic             clr;
    logic             e_valid;
    logic [IDX_W-1:0] e_idx;
    logic [N-1:0]     e_pend;
    logic             e_ovf;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rv, input logic [N-1:0] rq,
                              input logic rdy, input logic clr, input logic ev,
                              input logic [IDX_W-1:0] ei, input logic [N-1:0] ep,
                              input logic eo);
    vec_t v;
    v.rst = r; v.rv = rv; v.req = rq; v.rdy = rdy; v.clr = clr;
    v.e_valid = ev; v.e_idx = ei; v.e_pend = ep; v.e_ovf = eo;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int exp_i;
    rst = 1'b1; req_valid = 1'b0; req_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;

    //                rst rv req       rdy clr  valid idx pend      ovf
    // reset with requests active, then release
    vecs.push_back(mk(1, 1, 5'b11111, 1, 0,   0, 0, 5'b00000, 0));
    vecs.push_back(mk(1, 1, 5'b11111, 1, 0,   0, 0, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   0, 0, 5'b00000, 0));
    vecs.push_back(mk(0, 1, 5'b00001, 1, 0,   0, 0, 5'b00001, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   1, 0, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   0, 0, 5'b00000, 0));
    // serialisation of 10110
    vecs.push_back(mk(0, 1, 5'b10110, 1, 0,   0, 0, 5'b10110, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   1, 1, 5'b10100, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   1, 2, 5'b10000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   1, 4, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   0, 4, 5'b00000, 0));
    // backpressure on 01001
    vecs.push_back(mk(0, 1, 5'b01001, 0, 0,   0, 4, 5'b01001, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 0, 0,   1, 0, 5'b01000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 0, 0,   1, 0, 5'b01000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 0, 0,   1, 0, 5'b01000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 0, 0,   1, 0, 5'b01000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   1, 3, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   0, 3, 5'b00000, 0));
    // collision while index 2 is held
    vecs.push_back(mk(0, 1, 5'b00100, 0, 0,   0, 3, 5'b00100, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 0, 0,   1, 2, 5'b00000, 0));
    vecs.push_back(mk(0, 1, 5'b00100, 0, 0,   1, 2, 5'b00100, 0));
    vecs.push_back(mk(0, 1, 5'b00100, 0, 0,   1, 2, 5'b00100, 1));
    vecs.push_back(mk(0, 0, 5'b00000, 0, 1,   1, 2, 5'b00100, 0));
    vecs.push_back(mk(0, 1, 5'b00100, 0, 1,   1, 2, 5'b00100, 1));
    vecs.push_back(mk(0, 0, 5'b00000, 0, 1,   1, 2, 5'b00100, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   1, 2, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   0, 2, 5'b00000, 0));
    // set dominates clear on the load cycle
    vecs.push_back(mk(0, 1, 5'b00001, 1, 0,   0, 2, 5'b00001, 0));
    vecs.push_back(mk(0, 1, 5'b00001, 1, 0,   1, 0, 5'b00001, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   1, 0, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   0, 0, 5'b00000, 0));
    // reset in the middle of a held grant
    vecs.push_back(mk(0, 1, 5'b00110, 0, 0,   0, 0, 5'b00110, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 0, 0,   1, 1, 5'b00100, 0));
    vecs.push_back(mk(1, 1, 5'b11111, 0, 0,   0, 0, 5'b00000, 0));
    vecs.push_back(mk(0, 0, 5'b00000, 1, 0,   0, 0, 5'b00000, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      rst = vecs[k].rst; req_valid = vecs[k].rv; req_in = vecs[k].req;
      out_ready = vecs[k].rdy; clr_ovf = vecs[k].clr;
      tick();
      check($sformatf("vec%0d_valid", k), 32'(out_valid), 32'(vecs[k].e_valid));
      check($sformatf("vec%0d_idx", k),   32'(out_idx),   32'(vecs[k].e_idx));
      check($sformatf("vec%0d_pend", k),  32'(pending_o), 32'(vecs[k].e_pend));
      check($sformatf("vec%0d_ovf", k),   32'(ovf),       32'(vecs[k].e_ovf));
    end

    // All requests every cycle: priority mode decides the grant order.
    rst = 1'b0; req_valid = 1'b1; req_in = 5'b11111; out_ready = 1'b1; clr_ovf = 1'b0;
    tick();
    check("prio_first_valid", 32'(out_valid), 32'd0);
    check("prio_first_pend",  32'(pending_o), 32'h1f);
    for (int c = 0; c < 7; c++) begin
      tick();
`ifdef PRIO_ENC_QUEUE_RR_EN
      exp_i = c % N;
`else
      exp_i = 0;
`endif
      check($sformatf("prio%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("prio%0d_idx", c),   32'(out_idx),   32'(exp_i));
      check($sformatf("prio%0d_ovf", c),   32'(ovf),       32'd1);
    end
    rst = 1'b1; req_valid = 1'b0; req_in = '0;
    tick();
    rst = 1'b0;

    // Randomised traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = ($urandom_range(0, 1) == 1);
      req_in    = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_ovf   = ($urandom_range(0, 9) == 0);
      tick();
      check($sformatf("rnd%0d_valid", c), 32'(out_valid), 32'(m_valid));
      check($sformatf("rnd%0d_idx", c),   32'(out_idx),   32'(m_idx));
      check($sformatf("rnd%0d_pend", c),  32'(pending_o), 32'(m_pend_vec()));
      check($sformatf("rnd%0d_ovf", c),   32'(ovf),       32'(m_ovf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
